// File: rtl/ethernet_rx_if.sv
// RMII receive dibit stream in, parsed bus request (addr/data/rw + strobe) out.
interface ethernet_rx_if;
    logic        crsdv;
    logic [1:0]  rxd;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        rw_o;
    logic        valid_o;

    modport master (output crsdv, rxd, input addr_o, data_o, rw_o, valid_o);
    modport slave  (input crsdv, rxd, output addr_o, data_o, rw_o, valid_o);
endinterface

// File: rtl/ethernet_rx.sv
// Ethernet II receiver over RMII: filters on destination MAC and ethertype, checks FCS,
// and strobes the 5-byte request payload (rw, addr, data) for each good frame.
module ethernet_rx #(
    parameter logic [47:0] FPGA_MAC  = 48'h0,
    parameter logic [47:0] HOST_MAC  = 48'h0,
    parameter logic [15:0] ETHERTYPE = 16'h0
) (
    input  logic           clk,
    input  logic           rst,
    ethernet_rx_if.slave   rx_if
);

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, DROP
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] BYTE_MAX    = 11'd2047;

    state_t      state_q, state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [1:0]  dibit_cnt_q, dibit_cnt_d;
    logic [5:0]  byte_sr_q, byte_sr_d;
    logic [32:0] shadow_q, shadow_d;
    logic        reject_q, reject_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rw_q, rw_d;
    logic        valid_q, valid_d;

    logic [7:0]  cur_byte;
    logic        byte_done;
    logic [7:0]  mac_byte;
    logic        frame_good;

    // The host address is not filtered on; the parameter exists so both halves share one parameter set.
    if (HOST_MAC == FPGA_MAC) begin : g_host_is_self
    end

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign cur_byte   = {rx_if.rxd, byte_sr_q};
    assign byte_done  = (dibit_cnt_q == 2'd3);
    assign frame_good = !reject_q && (crc_q == CRC_RESIDUE) &&
                        (byte_cnt_q >= 11'd23) && (dibit_cnt_q == 2'd0);

    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt_q[2:0])
            3'd0:    mac_byte = FPGA_MAC[47:40];
            3'd1:    mac_byte = FPGA_MAC[39:32];
            3'd2:    mac_byte = FPGA_MAC[31:24];
            3'd3:    mac_byte = FPGA_MAC[23:16];
            3'd4:    mac_byte = FPGA_MAC[15:8];
            3'd5:    mac_byte = FPGA_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        byte_cnt_d  = byte_cnt_q;
        dibit_cnt_d = dibit_cnt_q;
        byte_sr_d   = byte_sr_q;
        shadow_d    = shadow_q;
        reject_d    = reject_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rw_d        = rw_q;
        valid_d     = 1'b0;

        // Shared datapath for every post-SFD dibit (header, payload, pad and FCS).
        if ((state_q == HEADER || state_q == PAYLOAD || state_q == PAD) && rx_if.crsdv) begin
            crc_d       = crc_dibit(crc_q, rx_if.rxd);
            byte_sr_d   = {rx_if.rxd, byte_sr_q[5:2]};
            dibit_cnt_d = dibit_cnt_q + 2'd1;
            if (byte_done && byte_cnt_q != BYTE_MAX) byte_cnt_d = byte_cnt_q + 11'd1;
        end

        case (state_q)
            WAIT_IDLE: begin
                if (!rx_if.crsdv) state_d = IDLE;
            end
            IDLE: begin
                if (rx_if.crsdv && rx_if.rxd == 2'b01) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = 5'd1;
                end
            end
            PREAMBLE: begin
                if (!rx_if.crsdv) begin
                    state_d = IDLE;
                end else if (rx_if.rxd == 2'b01) begin
                    if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                end else if (rx_if.rxd == 2'b11 && pre_cnt_q >= 5'd4) begin
                    state_d     = HEADER;
                    crc_d       = 32'hFFFFFFFF;
                    byte_cnt_d  = 11'd0;
                    dibit_cnt_d = 2'd0;
                    reject_d    = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
            HEADER: begin
                if (!rx_if.crsdv) begin
                    state_d = IDLE;
                end else if (byte_done) begin
                    if (byte_cnt_q < 11'd6 && cur_byte != mac_byte) reject_d = 1'b1;
                    if (byte_cnt_q == 11'd12 && cur_byte != ETHERTYPE[15:8]) reject_d = 1'b1;
                    if (byte_cnt_q == 11'd13 && cur_byte != ETHERTYPE[7:0]) reject_d = 1'b1;
                    if (byte_cnt_q == 11'd13) state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!rx_if.crsdv) begin
                    state_d = IDLE;
                end else if (byte_done) begin
                    shadow_d = {shadow_q[24:0], cur_byte};
                    if (byte_cnt_q == 11'd18) state_d = PAD;
                end
            end
            PAD: begin
                if (!rx_if.crsdv) begin
                    state_d = IDLE;
                    if (frame_good) begin
                        rw_d    = shadow_q[32];
                        addr_d  = shadow_q[31:16];
                        data_d  = shadow_q[15:0];
                        valid_d = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_if.crsdv) state_d = IDLE;
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            pre_cnt_q   <= '0;
            crc_q       <= '0;
            byte_cnt_q  <= '0;
            dibit_cnt_q <= '0;
            byte_sr_q   <= '0;
            shadow_q    <= '0;
            reject_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rw_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            byte_cnt_q  <= byte_cnt_d;
            dibit_cnt_q <= dibit_cnt_d;
            byte_sr_q   <= byte_sr_d;
            shadow_q    <= shadow_d;
            reject_q    <= reject_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rw_q        <= rw_d;
            valid_q     <= valid_d;
        end
    end

    assign rx_if.addr_o  = addr_q;
    assign rx_if.data_o  = data_q;
    assign rx_if.rw_o    = rw_q;
    assign rx_if.valid_o = valid_q;

endmodule

// File: tb/tb_ethernet_rx.sv
// Directed frame-level bench: a byte-queue model predicts strobe timing and held outputs each cycle.
module tb_ethernet_rx;

    localparam logic [47:0] MAC_F = 48'h02_12_34_56_78_9A;
    localparam logic [47:0] MAC_H = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [15:0] ETYPE = 16'h88B5;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    ethernet_rx_if rx_if ();

    ethernet_rx #(.FPGA_MAC(MAC_F), .HOST_MAC(MAC_H), .ETHERTYPE(ETYPE)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rx_if)
    );

    always #10 clk = ~clk;

    int      total = 0;
    int      bad   = 0;
    longint  cycle_cnt  = 0;
    longint  fire_cycle = -1;
    int      frame_no   = 0;
    byte_q_t frame_q;
    logic [15:0] obs_addr_q[$];

    logic [15:0] exp_addr = 16'h0, exp_data = 16'h0;
    logic        exp_rw = 1'b0;
    logic [15:0] pend_addr, pend_data;
    logic        pend_rw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    // Standard byte-wise Ethernet CRC-32; returns the FCS value (already inverted).
    function automatic logic [31:0] fcs_of(input byte_q_t q, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dest, input logic [15:0] etype,
                         input logic [39:0] pay, input int pad);
        logic [31:0] f;
        frame_q.delete();
        for (int i = 5; i >= 0; i--) frame_q.push_back(dest[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(MAC_H[8*i +: 8]);
        frame_q.push_back(etype[15:8]);
        frame_q.push_back(etype[7:0]);
        for (int i = 4; i >= 0; i--) frame_q.push_back(pay[8*i +: 8]);
        for (int i = 0; i < pad; i++) frame_q.push_back(8'h00);
        f = fcs_of(frame_q, frame_q.size());
        for (int i = 0; i < 4; i++) frame_q.push_back(f[8*i +: 8]);
    endtask

    function automatic bit model_good();
        int n;
        logic [31:0] f;
        n = frame_q.size();
        if (n < 23) return 1'b0;
        for (int i = 0; i < 6; i++)
            if (frame_q[i] != MAC_F[8*(5-i) +: 8]) return 1'b0;
        if ({frame_q[12], frame_q[13]} != ETYPE) return 1'b0;
        f = fcs_of(frame_q, n - 4);
        return {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]} == f;
    endfunction

    task automatic drive(input logic [1:0] d);
        rx_if.crsdv = 1'b1;
        rx_if.rxd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int pre_len, input int rst_at, input int gap);
        bit   ok;
        int   n;
        logic [7:0] b;
        n  = frame_q.size();
        ok = model_good() && (pre_len >= 4) && (rst_at < 0);
        frame_no++;
        $display("frame %0d: bytes=%0d preamble=%0d rst_at=%0d expect_strobe=%0d addr=%h data=%h rw=%0d",
                 frame_no, n, pre_len, rst_at, ok, {frame_q[15], frame_q[16]},
                 {frame_q[17], frame_q[18]}, frame_q[14][0]);
        for (int i = 0; i < pre_len; i++) drive(2'b01);
        drive(2'b11);
        for (int idx = 0; idx < n * 4; idx++) begin
            if (rst_at >= 0 && idx == rst_at)     rst = 1'b1;
            if (rst_at >= 0 && idx == rst_at + 3) rst = 1'b0;
            b = frame_q[idx / 4];
            drive(b[2*(idx % 4) +: 2]);
        end
        rx_if.crsdv = 1'b0;
        rx_if.rxd   = 2'b00;
        if (ok) begin
            pend_rw    = frame_q[14][0];
            pend_addr  = {frame_q[15], frame_q[16]};
            pend_data  = {frame_q[17], frame_q[18]};
            fire_cycle = cycle_cnt + 1;
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model reset: any cycle with rst sampled clears held outputs and cancels a pending strobe.
    always @(posedge clk) begin
        cycle_cnt = cycle_cnt + 1;
        if (rst) begin
            exp_addr   = 16'h0;
            exp_data   = 16'h0;
            exp_rw     = 1'b0;
            fire_cycle = -1;
        end
    end

    always @(negedge clk) begin
        if (cycle_cnt > 0) begin
            if (cycle_cnt == fire_cycle) begin
                exp_addr = pend_addr;
                exp_data = pend_data;
                exp_rw   = pend_rw;
            end
            chk("valid_o", {31'h0, rx_if.valid_o}, {31'h0, cycle_cnt == fire_cycle});
            chk("addr_o", {16'h0, rx_if.addr_o}, {16'h0, exp_addr});
            chk("data_o", {16'h0, rx_if.data_o}, {16'h0, exp_data});
            chk("rw_o", {31'h0, rx_if.rw_o}, {31'h0, exp_rw});
            if (rx_if.valid_o === 1'b1) obs_addr_q.push_back(rx_if.addr_o);
        end
    end

    initial begin
        byte_q_t ref_q;
        int      np;
        rx_if.crsdv = 1'b0;
        rx_if.rxd   = 2'b00;

        ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_check_value", fcs_of(ref_q, 9), 32'hCBF43926);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #9;
        chk("reset_valid", {31'h0, rx_if.valid_o}, 32'h0);
        chk("reset_addr", {16'h0, rx_if.addr_o}, 32'h0);
        @(posedge clk);
        #1;

        // 1: good write frame
        np = obs_addr_q.size();
        build(MAC_F, ETYPE, 40'h01_1234_ABCD, 41);
        send(31, -1, 4);
        chk("t1_pulses", obs_addr_q.size() - np, 1);
        chk("t1_rw", {31'h0, rx_if.rw_o}, 32'h1);
        chk("t1_addr", {16'h0, rx_if.addr_o}, 32'h1234);
        chk("t1_data", {16'h0, rx_if.data_o}, 32'hABCD);

        // 2: good read frame
        build(MAC_F, ETYPE, 40'h00_0005_0000, 41);
        send(31, -1, 4);
        chk("t2_rw", {31'h0, rx_if.rw_o}, 32'h0);
        chk("t2_addr", {16'h0, rx_if.addr_o}, 32'h0005);
        chk("t2_data", {16'h0, rx_if.data_o}, 32'h0000);

        // 3: payload bit flipped after FCS computed
        np = obs_addr_q.size();
        build(MAC_F, ETYPE, 40'h01_1234_ABCD, 41);
        frame_q[17] = frame_q[17] ^ 8'h01;
        send(31, -1, 4);
        chk("t3_pulses", obs_addr_q.size() - np, 0);
        chk("t3_addr_held", {16'h0, rx_if.addr_o}, 32'h0005);

        // 4: wrong destination last byte, then wrong ethertype
        np = obs_addr_q.size();
        build(MAC_F ^ 48'h1, ETYPE, 40'h01_1234_ABCD, 41);
        send(31, -1, 4);
        build(MAC_F, ETYPE ^ 16'h0100, 40'h01_1234_ABCD, 41);
        send(31, -1, 4);
        chk("t4_pulses", obs_addr_q.size() - np, 0);

        // 5: reset mid-payload, then a good frame
        np = obs_addr_q.size();
        build(MAC_F, ETYPE, 40'h01_1234_ABCD, 41);
        send(31, 14 * 4 + 8, 4);
        chk("t5_reset_pulses", obs_addr_q.size() - np, 0);
        chk("t5_addr_after_rst", {16'h0, rx_if.addr_o}, 32'h0);
        build(MAC_F, ETYPE, 40'h01_1234_ABCD, 41);
        send(31, -1, 4);
        chk("t5_pulses", obs_addr_q.size() - np, 1);
        chk("t5_addr", {16'h0, rx_if.addr_o}, 32'h1234);
        chk("t5_data", {16'h0, rx_if.data_o}, 32'hABCD);

        // 6: back-to-back frames with one idle cycle, minimum-length frame, short preamble
        np = obs_addr_q.size();
        build(MAC_F, ETYPE, 40'h01_0001_1111, 41);
        send(31, -1, 1);
        build(MAC_F, ETYPE, 40'h01_0002_2222, 41);
        send(31, -1, 4);
        chk("t6_pair_pulses", obs_addr_q.size() - np, 2);
        if (obs_addr_q.size() - np == 2) begin
            chk("t6_first_addr", {16'h0, obs_addr_q[np]}, 32'h0001);
            chk("t6_second_addr", {16'h0, obs_addr_q[np+1]}, 32'h0002);
        end
        build(MAC_F, ETYPE, 40'h00_0003_3333, 0);
        send(6, -1, 4);
        chk("t6_min_addr", {16'h0, rx_if.addr_o}, 32'h0003);
        np = obs_addr_q.size();
        build(MAC_F, ETYPE, 40'h01_0004_4444, 41);
        send(3, -1, 4);
        chk("t6_short_pre_pulses", obs_addr_q.size() - np, 0);
        chk("t6_short_pre_addr", {16'h0, rx_if.addr_o}, 32'h0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ethernet_rx.md
Name: ethernet_rx

Overview:
- Receive half of the Ethernet bus interface. Consumes RMII receive dibits from the PHY and parses Ethernet II frames.
- Filters frames on destination MAC and ethertype, and checks the FCS.
- For each good frame, presents the 5-byte request payload (rw flag, address, write data) to the bus core as a single-cycle valid strobe.
- It is the request-side counterpart of the transmit path, which returns read data to the host.

Parameters:
FPGA_MAC, 0, 48-bit MAC address of this device; required destination address.
HOST_MAC, 0, 48-bit host MAC; carried for symmetry with the transmit path, not checked.
ETHERTYPE, 0, 16-bit ethertype; frame accepted only on exact match.

Ports:
clk  input  1  50 MHz RMII reference clock; one dibit per cycle.
rst  input  1  synchronous, active-high reset.
crsdv  input  1  RMII carrier-sense/data-valid.
rxd  input  2  RMII receive dibit.
addr_o  output  16  request address.
data_o  output  16  request write data.
rw_o  output  1  1 = write, 0 = read.
valid_o  output  1  one-cycle strobe; addr_o/data_o/rw_o are valid while it is high.

Behaviour:
- Reset values: addr_o=0, data_o=0, rw_o=0, valid_o=0. Reset forces state to WAIT_IDLE and clears all counters and the CRC.
- Bit order:
  - Each byte arrives LSB-first as 4 dibits; the first dibit is bits [1:0] and rxd[0] is the lower bit.
  - Multi-byte fields are MSB byte first.
- Payload layout (bytes after ethertype): byte0 bit0 = rw, bytes1-2 = addr, bytes3-4 = data. Remaining bytes up to FCS are padding and are ignored.
- States:
  - WAIT_IDLE: exit to IDLE on the first cycle with crsdv=0. Prevents locking onto a frame already in progress after reset.
  - IDLE: on crsdv=1 && rxd=01, go to PREAMBLE with the preamble count set to 1. crsdv=1 with rxd=00 stays in IDLE (PHY startup tolerance).
  - PREAMBLE:
    - rxd=01 increments the count, saturating at 31.
    - rxd=11 with count>=4 goes to HEADER and clears the CRC to all-ones.
    - rxd=11 with count<4, rxd=00, or rxd=10 goes to DROP.
    - crsdv=0 goes to IDLE.
  - HEADER: assembles 14 bytes. Destination is compared to FPGA_MAC, source is ignored, ethertype is compared to ETHERTYPE. A mismatch sets a reject flag; the FSM continues. After byte 13, go to PAYLOAD.
  - PAYLOAD: assembles 5 bytes into shadow registers (not the outputs), then goes to PAD.
  - PAD: consumes dibits until crsdv=0.
  - DROP: waits for crsdv=0, then goes to IDLE.
- CRC:
  - Standard CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF), updated 2 bits per cycle on every dibit after the SFD, including the FCS.
  - Frame is good when the residue equals 0xDEBB20E3 (reflected form; equivalently 0xC704DD7B non-reflected).
- End of frame, on the first cycle crsdv=0 in PAD:
  - Good iff no reject, residue matches, byte count >= 23 (14+5+4), and dibit count is a multiple of 4.
  - If good: copy shadows to addr_o/data_o/rw_o and assert valid_o on the next cycle for exactly 1 cycle.
  - If bad: no strobe.
  - Either way, go to IDLE.
- crsdv falling in HEADER or PAYLOAD: truncated frame; go to IDLE with no strobe.
- Outputs hold their last accepted values between strobes. Rejected frames never disturb them.
- Minimum inter-frame gap handled: 1 cycle of crsdv=0. IDLE is entered the same cycle valid_o fires, so the next preamble can start immediately.
- Byte counter saturates at 2047. Longer frames are still terminated by crsdv=0.
- rst during a frame: outputs and state reset. valid_o is not asserted for that frame, even if its FCS completes after rst is released.

Test Plan:
1. Write frame: dest=FPGA_MAC, ethertype=ETHERTYPE, payload 01 12 34 AB CD, 41 zero pad bytes, correct FCS -> exactly one valid_o pulse, 1 cycle after crsdv falls; rw_o=1, addr_o=0x1234, data_o=0xABCD.
2. Read frame, payload 00 00 05 00 00 -> one pulse; rw_o=0, addr_o=0x0005, data_o=0x0000.
3. Frame from scenario 1 with one payload bit flipped (FCS unchanged) -> no valid_o; outputs retain the scenario 2 values.
4. Destination MAC differing in the last byte, then a separate frame with wrong ethertype, both with correct FCS -> no valid_o for either.
5. Assert rst for 3 cycles mid-payload; rest of frame delivered unchanged; then a good scenario 1 frame -> no strobe for the first frame; exactly one strobe with 0x1234/0xABCD for the second.
6. Two good frames (addr 0x0001, then 0x0002) separated by 1 cycle of crsdv=0; also a preamble of only 3 dibits of 01 before the SFD -> two strobes in order for the first pair; the short-preamble frame is dropped.
